// File: rtl/uart_rx_framed.sv
// uart_rx_framed: oversampling-free UART receiver with framing checks.
// A falling edge on the synchronized line starts a half-bit timer; the start
// bit is re-checked at its centre, then every following bit is sampled once
// per CLK_CYCLES by a down-counting bit timer. Completed frames are published
// into a one-deep holding register with valid/ack handshake.
//
// Ports:
//   clk        - single clock, rising edge
//   reset_n    - synchronous active-low reset
//   uart_rx    - asynchronous serial line, idle high
//   data       - last accepted word, LSB received first
//   valid      - data holds an unconsumed word
//   ack        - consumer strobe, clears valid
//   parity_err - parity mismatch on the word in data
//   frame_err  - a stop bit was sampled low on the word in data
//   overrun    - sticky, a completed frame was dropped because valid was held
//   busy       - receiver is inside a frame (state other than IDLE)
//
// state | meaning
// IDLE  | waiting for a falling edge on rx_s (line must have been seen high)
// START | timing to the centre of the start bit, glitch reject there
// DATA  | sampling DATA_BITS data bits, LSB first
// PAR   | sampling the parity bit (only when PARITY != 0)
// STOP  | sampling STOP_BITS stop bits; the last sample ends the frame
module uart_rx_framed #(
  parameter int CLK_CYCLES = 868,
  parameter int CTR_WIDTH  = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  localparam logic [CTR_WIDTH-1:0] CTR_HALF  = CTR_WIDTH'(CLK_CYCLES / 2 - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_FULL  = CTR_WIDTH'(CLK_CYCLES - 1);
  localparam logic [3:0]           LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]           LAST_STOP = 4'(STOP_BITS - 1);

  state_t                 state, state_next;
  logic [CTR_WIDTH-1:0]   ctr, ctr_next;
  logic [3:0]             bit_cnt, bit_cnt_next;
  logic                   rx_meta, rx_s;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_err_r, stop_err;
  logic                   pub_pending;
  logic                   line_idle;
  logic                   frame_start, shift_en, par_en, stop_en, frame_done;
  logic                   tick;

  assign tick = (ctr == '0);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      ctr     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      ctr     <= ctr_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    ctr_next     = ctr;
    bit_cnt_next = bit_cnt;
    frame_start  = 1'b0;
    shift_en     = 1'b0;
    par_en       = 1'b0;
    stop_en      = 1'b0;
    frame_done   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s && line_idle) begin
          state_next = START;
          ctr_next   = CTR_HALF;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            state_next   = DATA;
            ctr_next     = CTR_FULL;
            bit_cnt_next = '0;
            frame_start  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          ctr_next = ctr - 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          ctr_next = CTR_FULL;
          shift_en = 1'b1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_next = '0;
            state_next   = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end else begin
          ctr_next = ctr - 1'b1;
        end
      end
      PAR: begin
        if (tick) begin
          ctr_next   = CTR_FULL;
          par_en     = 1'b1;
          state_next = STOP;
        end else begin
          ctr_next = ctr - 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          ctr_next = CTR_FULL;
          stop_en  = 1'b1;
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_next = '0;
            state_next   = IDLE;
            frame_done   = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end else begin
          ctr_next = ctr - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      shreg       <= '0;
      par_err_r   <= 1'b0;
      stop_err    <= 1'b0;
      pub_pending <= 1'b0;
      line_idle   <= 1'b1;
      data        <= '0;
      valid       <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;

      if (frame_start) begin
        par_err_r <= 1'b0;
        stop_err  <= 1'b0;
      end
      if (shift_en)
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      // odd parity expects the XOR of data and parity to be 1, even expects 0
      if (par_en)
        par_err_r <= (^shreg) ^ rx_s ^ (PARITY == 1);
      if (stop_en && !rx_s)
        stop_err <= 1'b1;

      // a break leaves the line low after the frame; block re-triggering
      // until the line has been seen high again
      if (frame_done)
        line_idle <= 1'b0;
      else if (rx_s)
        line_idle <= 1'b1;

      pub_pending <= frame_done;

      if (pub_pending) begin
        if (!valid || ack) begin
          data       <= shreg;
          parity_err <= par_err_r;
          frame_err  <= stop_err;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (ack && valid) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
module tb_uart_rx_framed;

  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_a, rx_b, ack_a, ack_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
  logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  logic vprev  = 1'b0;

  uart_rx_framed #(.CLK_CYCLES(16), .CTR_WIDTH(8), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .uart_rx(rx_a), .data(data_a), .valid(valid_a), .ack(ack_a),
    .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a));

  uart_rx_framed #(.CLK_CYCLES(16), .CTR_WIDTH(8), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .uart_rx(rx_b), .data(data_b), .valid(valid_b), .ack(ack_b),
    .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_a && !vprev && rise_cyc == 0) rise_cyc = cyc;
    vprev = valid_a;
  end

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       ack_first;
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_perr;
    logic       e_ferr;
    logic       e_ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack;
    ack_a = 1'b1;
    cycles(1);
    ack_a = 1'b0;
  endtask

  // bits[0] goes on the line first; each bit held BIT clocks
  task automatic send(input bit sel_b, input logic [15:0] bits, input int nbits, input int ack_at);
    fall_cyc = cyc;
    for (int i = 0; i < nbits * BIT; i++) begin
      if (sel_b) rx_b = bits[i / BIT];
      else       rx_a = bits[i / BIT];
      ack_a = (i == ack_at);
      cycles(1);
    end
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    ack_a = 1'b0;
  endtask

  function automatic logic [15:0] frame_a(input logic [7:0] d, input logic p, input logic s);
    return {5'b0, s, p, d, 1'b0};
  endfunction

  initial begin
    vecs[0] = '{d:8'hA5, p:1'b0, s:1'b1, ack_first:1'b0, e_data:8'hA5, e_valid:1'b1, e_perr:1'b0, e_ferr:1'b0, e_ovr:1'b0};
    vecs[1] = '{d:8'h3C, p:1'b1, s:1'b1, ack_first:1'b1, e_data:8'h3C, e_valid:1'b1, e_perr:1'b1, e_ferr:1'b0, e_ovr:1'b0};
    vecs[2] = '{d:8'h3C, p:1'b0, s:1'b1, ack_first:1'b1, e_data:8'h3C, e_valid:1'b1, e_perr:1'b0, e_ferr:1'b0, e_ovr:1'b0};
    vecs[3] = '{d:8'h55, p:1'b0, s:1'b0, ack_first:1'b1, e_data:8'h55, e_valid:1'b1, e_perr:1'b0, e_ferr:1'b1, e_ovr:1'b0};
    vecs[4] = '{d:8'h11, p:1'b0, s:1'b1, ack_first:1'b1, e_data:8'h11, e_valid:1'b1, e_perr:1'b0, e_ferr:1'b0, e_ovr:1'b0};
    vecs[5] = '{d:8'h22, p:1'b0, s:1'b1, ack_first:1'b0, e_data:8'h11, e_valid:1'b1, e_perr:1'b0, e_ferr:1'b0, e_ovr:1'b1};

    reset_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; ack_a = 1'b0; ack_b = 1'b0;
    cycles(5);
    chk("rst_data", {24'b0, data_a}, 32'h0);
    chk("rst_valid", {31'b0, valid_a}, 32'h0);
    chk("rst_perr", {31'b0, perr_a}, 32'h0);
    chk("rst_ferr", {31'b0, ferr_a}, 32'h0);
    chk("rst_ovr", {31'b0, ovr_a}, 32'h0);
    chk("rst_busy", {31'b0, busy_a}, 32'h0);
    chk("rst_valid_b", {31'b0, valid_b}, 32'h0);
    reset_n = 1'b1;
    cycles(5);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].ack_first) begin
        pulse_ack();
        cycles(2);
      end
      send(1'b0, frame_a(vecs[v].d, vecs[v].p, vecs[v].s), 11, -1);
      cycles(4);
      chk($sformatf("v%0d_valid", v), {31'b0, valid_a}, {31'b0, vecs[v].e_valid});
      chk($sformatf("v%0d_data", v), {24'b0, data_a}, {24'b0, vecs[v].e_data});
      chk($sformatf("v%0d_perr", v), {31'b0, perr_a}, {31'b0, vecs[v].e_perr});
      chk($sformatf("v%0d_ferr", v), {31'b0, ferr_a}, {31'b0, vecs[v].e_ferr});
      chk($sformatf("v%0d_ovr", v), {31'b0, ovr_a}, {31'b0, vecs[v].e_ovr});
      if (v == 0) begin
        checks++;
        if (rise_cyc - fall_cyc < 170 || rise_cyc - fall_cyc > 172) begin
          failures++;
          $display("FAIL latency actual=%0d expected=170..172", rise_cyc - fall_cyc);
        end
      end
    end

    // ack clears valid and overrun, word held
    pulse_ack();
    cycles(1);
    chk("ack_valid", {31'b0, valid_a}, 32'h0);
    chk("ack_ovr", {31'b0, ovr_a}, 32'h0);
    chk("ack_data_hold", {24'b0, data_a}, 32'h11);

    // short low pulse on an idle line is rejected at the start-bit centre
    rx_a = 1'b0;
    cycles(4);
    rx_a = 1'b1;
    cycles(2);
    chk("glitch_busy_mid", {31'b0, busy_a}, 32'h1);
    cycles(20);
    chk("glitch_busy_end", {31'b0, busy_a}, 32'h0);
    chk("glitch_valid", {31'b0, valid_a}, 32'h0);

    // publish coinciding with ack loads the new word without overrun
    send(1'b0, frame_a(8'h11, 1'b0, 1'b1), 11, -1);
    cycles(4);
    chk("pre_ackpub_data", {24'b0, data_a}, 32'h11);
    send(1'b0, frame_a(8'h22, 1'b0, 1'b1), 11, 171);
    cycles(4);
    chk("ackpub_data", {24'b0, data_a}, 32'h22);
    chk("ackpub_valid", {31'b0, valid_a}, 32'h1);
    chk("ackpub_ovr", {31'b0, ovr_a}, 32'h0);

    // reset during data bit 4 of 0x77 abandons the frame
    pulse_ack();
    fall_cyc = cyc;
    for (int i = 0; i < 92; i++) begin
      rx_a = frame_a(8'h77, 1'b0, 1'b1) >> (i / BIT);
      if (i >= 88) begin
        rx_a    = 1'b1;
        reset_n = 1'b0;
      end
      cycles(1);
    end
    reset_n = 1'b1;
    rx_a    = 1'b1;
    cycles(200);
    chk("rstmid_valid", {31'b0, valid_a}, 32'h0);
    chk("rstmid_busy", {31'b0, busy_a}, 32'h0);
    chk("rstmid_data", {24'b0, data_a}, 32'h0);
    send(1'b0, frame_a(8'h81, 1'b0, 1'b1), 11, -1);
    cycles(4);
    chk("post_rst_data", {24'b0, data_a}, 32'h81);
    chk("post_rst_valid", {31'b0, valid_a}, 32'h1);

    // break: line held low gives a zero word with frame error, then no re-trigger
    pulse_ack();
    rx_a = 1'b0;
    cycles(300);
    chk("break_valid", {31'b0, valid_a}, 32'h1);
    chk("break_data", {24'b0, data_a}, 32'h0);
    chk("break_ferr", {31'b0, ferr_a}, 32'h1);
    chk("break_perr", {31'b0, perr_a}, 32'h0);
    chk("break_busy", {31'b0, busy_a}, 32'h0);
    pulse_ack();
    cycles(60);
    chk("break_no_retrig_valid", {31'b0, valid_a}, 32'h0);
    chk("break_no_retrig_busy", {31'b0, busy_a}, 32'h0);
    rx_a = 1'b1;
    cycles(20);

    // 7 data bits, odd parity, two stop bits, second stop low
    send(1'b1, {5'b0, 1'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 11, -1);
    cycles(4);
    chk("b_valid", {31'b0, valid_b}, 32'h1);
    chk("b_data", {25'b0, data_b}, 32'h41);
    chk("b_perr", {31'b0, perr_b}, 32'h0);
    chk("b_ferr", {31'b0, ferr_b}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
